axi_snoop_master: RTL and testbench

Interconnect-side ACE snoop initiator: the responder-facing counterpart of the CPU bridge's snoop channel logic. Accepts one snoop request at a time from the coherence controller and drives it onto the AC channel. It then collects the CR response and, when data is transferred, assembles the 4-beat CD burst into one L1 line. The result is returned to the controller as a single response. One instance sits per snooped CPU port in the ACE interconnect.

---
 rtl/axi_snoop_master_pkg.sv | 37 +++
 rtl/axi_snoop_master_if.sv | 40 ++++
 rtl/axi_snoop_master.sv | 104 ++++++++++
 tb/tb_axi_snoop_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_snoop_master_pkg.sv
// axi_snoop_master_pkg: shared states, CRRESP bit indices and register bundle for the snoop initiator.
// The timeout fields exist only when SNOOP_TIMEOUT_EN is defined.
package axi_snoop_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AC_REQ  = 3'd1,
        ST_CR_WAIT = 3'd2,
        ST_CD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    localparam int CR_DATA_TRANSFER = 0;
    localparam int CR_ERROR         = 1;
    localparam int CR_PASS_DIRTY    = 2;
    localparam int CR_IS_SHARED     = 3;
    localparam int CR_WAS_UNIQUE    = 4;

    localparam logic [2:0] AC_PROT = 3'b010;

    typedef struct packed {
        state_e       state;
        logic         req_ready;
        logic [3:0]   snoop;
        logic [4:0]   cr;
        logic [255:0] line;
        logic [1:0]   beat;
        logic         last_seen;
`ifdef SNOOP_TIMEOUT_EN
        logic         tmo;
        logic [15:0]  cnt;
`endif
    } axi_snoop_master_registers;

    localparam axi_snoop_master_registers axi_snoop_master_r_reset = '{state: ST_IDLE, default: '0};

endpackage

// File: rtl/axi_snoop_master_if.sv
// axi_snoop_master_if: request, AC, CR, CD and response channels between the snoop initiator and its environment.
interface axi_snoop_master_if #(
    parameter int abits = 48
) ();
    logic             i_req_valid;
    logic             o_req_ready;
    logic [abits-1:0] i_req_addr;
    logic [3:0]       i_req_snoop;
    logic             o_ac_valid;
    logic             i_ac_ready;
    logic [abits-1:0] o_ac_addr;
    logic [3:0]       o_ac_snoop;
    logic [2:0]       o_ac_prot;
    logic             i_cr_valid;
    logic             o_cr_ready;
    logic [4:0]       i_cr_resp;
    logic             i_cd_valid;
    logic             o_cd_ready;
    logic [63:0]      i_cd_data;
    logic             i_cd_last;
    logic             o_resp_valid;
    logic             i_resp_ready;
    logic [4:0]       o_resp_cr;
    logic [255:0]     o_resp_data;
    logic             o_resp_timeout;

    modport master (
        input  i_req_valid, i_req_addr, i_req_snoop, i_ac_ready, i_cr_valid, i_cr_resp,
        input  i_cd_valid, i_cd_data, i_cd_last, i_resp_ready,
        output o_req_ready, o_ac_valid, o_ac_addr, o_ac_snoop, o_ac_prot, o_cr_ready,
        output o_cd_ready, o_resp_valid, o_resp_cr, o_resp_data, o_resp_timeout
    );

    modport slave (
        output i_req_valid, i_req_addr, i_req_snoop, i_ac_ready, i_cr_valid, i_cr_resp,
        output i_cd_valid, i_cd_data, i_cd_last, i_resp_ready,
        input  o_req_ready, o_ac_valid, o_ac_addr, o_ac_snoop, o_ac_prot, o_cr_ready,
        input  o_cd_ready, o_resp_valid, o_resp_cr, o_resp_data, o_resp_timeout
    );
endinterface

// File: rtl/axi_snoop_master.sv
// axi_snoop_master: issues one ACE snoop on AC, collects CR and the 4-beat CD line, returns a single response.
// Optional watchdog on the CR/CD wait enabled by defining SNOOP_TIMEOUT_EN.
module axi_snoop_master
    import axi_snoop_master_pkg::*;
#(
    parameter int abits          = 48,
    parameter int timeout_cycles = 1024
) (
    input logic                 i_clk,
    input logic                 i_nrst,
    axi_snoop_master_if.master  bus
);

    axi_snoop_master_registers r_q, r_d;
    logic [abits-1:0] addr_q, addr_d;
    logic cd_hs, cr_hs;

    // Next-state: FSM transitions, request latching and CD beat assembly.
    always_comb begin
        r_d    = r_q;
        addr_d = addr_q;
        cd_hs  = bus.i_cd_valid && (r_q.state == ST_CR_WAIT || r_q.state == ST_CD_WAIT);
        cr_hs  = bus.i_cr_valid && r_q.state == ST_CR_WAIT;
        case (r_q.state)
            ST_IDLE: begin
                if (bus.i_req_valid && r_q.req_ready) begin
                    addr_d      = bus.i_req_addr & ~abits'(5'h1f);
                    r_d.snoop   = bus.i_req_snoop;
                    r_d.cr      = '0;
                    r_d.line    = '0;
                    r_d.beat    = '0;
                    r_d.last_seen = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
                    r_d.tmo     = 1'b0;
`endif
                    r_d.state   = ST_AC_REQ;
                end
            end
            ST_AC_REQ: begin
                if (bus.i_ac_ready) begin
                    r_d.state = ST_CR_WAIT;
`ifdef SNOOP_TIMEOUT_EN
                    r_d.cnt   = '0;
`endif
                end
            end
            ST_CR_WAIT, ST_CD_WAIT: begin
                if (cd_hs) begin
                    r_d.line[{r_q.beat, 6'b0} +: 64] = bus.i_cd_data;
                    r_d.beat = r_q.beat + 2'd1;
                    if (bus.i_cd_last) r_d.last_seen = 1'b1;
                end
                if (cr_hs) begin
                    r_d.cr    = bus.i_cr_resp;
                    r_d.state = (!bus.i_cr_resp[CR_DATA_TRANSFER] || r_q.last_seen || (cd_hs && bus.i_cd_last))
                                ? ST_RESP : ST_CD_WAIT;
                end
                if (r_q.state == ST_CD_WAIT && cd_hs && bus.i_cd_last) r_d.state = ST_RESP;
`ifdef SNOOP_TIMEOUT_EN
                if (r_q.cnt == 16'(timeout_cycles - 1)) begin
                    r_d       = r_q;
                    r_d.state = ST_RESP;
                    r_d.tmo   = 1'b1;
                end else begin
                    r_d.cnt = r_q.cnt + 16'd1;
                end
`endif
            end
            ST_RESP: begin
                if (bus.i_resp_ready) r_d.state = ST_IDLE;
            end
            default: r_d.state = ST_IDLE;
        endcase
        r_d.req_ready = r_d.state == ST_IDLE;
    end

    // State register; reset returns to idle with request ready held low until the first clock.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_q    <= axi_snoop_master_r_reset;
            addr_q <= '0;
        end else begin
            r_q    <= r_d;
            addr_q <= addr_d;
        end
    end

    assign bus.o_req_ready  = r_q.req_ready;
    assign bus.o_ac_valid   = r_q.state == ST_AC_REQ;
    assign bus.o_ac_addr    = addr_q;
    assign bus.o_ac_snoop   = r_q.snoop;
    assign bus.o_ac_prot    = AC_PROT;
    assign bus.o_cr_ready   = r_q.state == ST_CR_WAIT;
    assign bus.o_cd_ready   = r_q.state == ST_CR_WAIT || r_q.state == ST_CD_WAIT;
    assign bus.o_resp_valid = r_q.state == ST_RESP;
    assign bus.o_resp_cr    = r_q.cr;
    assign bus.o_resp_data  = r_q.line;
`ifdef SNOOP_TIMEOUT_EN
    assign bus.o_resp_timeout = r_q.tmo;
`else
    assign bus.o_resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_snoop_master.sv
// tb_axi_snoop_master: directed self-checking bench for axi_snoop_master (watchdog case depends on SNOOP_TIMEOUT_EN).
module tb_axi_snoop_master;

`ifdef SNOOP_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    axi_snoop_master_if #(.abits(48)) bus ();

    axi_snoop_master #(.abits(48), .timeout_cycles(TMO)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [47:0] addr, input logic [3:0] snoop);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = addr;
        bus.i_req_snoop = snoop;
        tick();
        bus.i_req_valid = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic last);
        bus.i_cd_valid = 1'b1;
        bus.i_cd_data  = d;
        bus.i_cd_last  = last;
        tick();
        bus.i_cd_valid = 1'b0;
        bus.i_cd_last  = 1'b0;
    endtask

    initial begin
        bus.i_req_valid = 1'b0; bus.i_req_addr = '0; bus.i_req_snoop = '0;
        bus.i_ac_ready = 1'b0; bus.i_cr_valid = 1'b0; bus.i_cr_resp = '0;
        bus.i_cd_valid = 1'b0; bus.i_cd_data = '0; bus.i_cd_last = 1'b0;
        bus.i_resp_ready = 1'b0;
        tick(); tick();
        chk("rst_req_ready", bus.o_req_ready, 0);
        chk("rst_ac_valid", bus.o_ac_valid, 0);
        chk("rst_cd_ready", bus.o_cd_ready, 0);
        chk("rst_resp_valid", bus.o_resp_valid, 0);
        chk("rst_resp_data", bus.o_resp_data, 0);
        nrst = 1'b1;
        tick();
        chk("rel_req_ready", bus.o_req_ready, 1);
        chk("ac_prot", bus.o_ac_prot, 3'b010);

        // ReadOnce without data: cycle-exact latency
        issue(48'h0000_8000_1234, 4'b0000);
        chk("t1_ac_valid", bus.o_ac_valid, 1);
        chk("t1_ac_addr", bus.o_ac_addr, 48'h0000_8000_1220);
        chk("t1_req_ready", bus.o_req_ready, 0);
        bus.i_ac_ready = 1'b1;
        tick();
        bus.i_ac_ready = 1'b0;
        chk("t1_cr_ready", bus.o_cr_ready, 1);
        chk("t1_cd_ready", bus.o_cd_ready, 1);
        chk("t1_ac_valid_off", bus.o_ac_valid, 0);
        bus.i_cr_valid = 1'b1; bus.i_cr_resp = 5'b00000;
        tick();
        bus.i_cr_valid = 1'b0;
        chk("t1_resp_valid", bus.o_resp_valid, 1);
        chk("t1_resp_data", bus.o_resp_data, 0);
        chk("t1_resp_cr", bus.o_resp_cr, 0);
        chk("t1_timeout", bus.o_resp_timeout, 0);
        bus.i_resp_ready = 1'b1;
        tick();
        bus.i_resp_ready = 1'b0;
        chk("t1_idle_ready", bus.o_req_ready, 1);
        chk("t1_idle_resp", bus.o_resp_valid, 0);

        // CleanInvalid, CR first then 4 beats in cd_wait
        issue(48'h0000_0000_1040, 4'b1001);
        chk("t2_ac_snoop", bus.o_ac_snoop, 4'b1001);
        bus.i_ac_ready = 1'b1;
        tick();
        bus.i_ac_ready = 1'b0;
        bus.i_cr_valid = 1'b1; bus.i_cr_resp = 5'b00101;
        tick();
        bus.i_cr_valid = 1'b0;
        chk("t2_cd_wait_cr_ready", bus.o_cr_ready, 0);
        chk("t2_cd_wait_cd_ready", bus.o_cd_ready, 1);
        beat(64'h1111_1111_1111_1111, 1'b0);
        beat(64'h2222_2222_2222_2222, 1'b0);
        beat(64'h3333_3333_3333_3333, 1'b0);
        chk("t2_no_resp_yet", bus.o_resp_valid, 0);
        beat(64'h4444_4444_4444_4444, 1'b1);
        chk("t2_resp_valid", bus.o_resp_valid, 1);
        chk("t2_resp_data", bus.o_resp_data,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("t2_resp_cr", bus.o_resp_cr, 5'h05);
        bus.i_resp_ready = 1'b1;
        tick();
        bus.i_resp_ready = 1'b0;

        // All CD beats before CR
        issue(48'h0000_0000_2000, 4'b0001);
        bus.i_ac_ready = 1'b1;
        tick();
        bus.i_ac_ready = 1'b0;
        beat(64'haaaa_aaaa_aaaa_aaaa, 1'b0);
        beat(64'hbbbb_bbbb_bbbb_bbbb, 1'b0);
        beat(64'hcccc_cccc_cccc_cccc, 1'b0);
        beat(64'hdddd_dddd_dddd_dddd, 1'b1);
        chk("t3_still_cr_wait", bus.o_cr_ready, 1);
        chk("t3_no_resp", bus.o_resp_valid, 0);
        bus.i_cr_valid = 1'b1; bus.i_cr_resp = 5'b00001;
        tick();
        bus.i_cr_valid = 1'b0;
        chk("t3_resp_valid", bus.o_resp_valid, 1);
        chk("t3_resp_data", bus.o_resp_data,
            {64'hdddd_dddd_dddd_dddd, 64'hcccc_cccc_cccc_cccc, 64'hbbbb_bbbb_bbbb_bbbb, 64'haaaa_aaaa_aaaa_aaaa});
        chk("t3_resp_cr", bus.o_resp_cr, 5'h01);
        bus.i_resp_ready = 1'b1;
        tick();
        bus.i_resp_ready = 1'b0;

        // Back-pressure on AC and on response
        issue(48'h0001_2345_678f, 4'b0111);
        for (int i = 0; i < 10; i++) begin
            chk("t4_ac_valid_hold", bus.o_ac_valid, 1);
            chk("t4_ac_addr_hold", bus.o_ac_addr, 48'h0001_2345_6780);
            chk("t4_ac_snoop_hold", bus.o_ac_snoop, 4'b0111);
            tick();
        end
        bus.i_ac_ready = 1'b1;
        tick();
        bus.i_ac_ready = 1'b0;
        bus.i_cr_valid = 1'b1; bus.i_cr_resp = 5'b10000;
        tick();
        bus.i_cr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_resp_hold", bus.o_resp_valid, 1);
            chk("t4_resp_cr_hold", bus.o_resp_cr, 5'h10);
            chk("t4_resp_data_hold", bus.o_resp_data, 0);
            chk("t4_req_ready_low", bus.o_req_ready, 0);
            tick();
        end
        bus.i_resp_ready = 1'b1;
        tick();
        bus.i_resp_ready = 1'b0;
        chk("t4_req_ready_back", bus.o_req_ready, 1);

        // Reset in cd_wait after two beats
        issue(48'h0000_0000_3000, 4'b1000);
        bus.i_ac_ready = 1'b1;
        tick();
        bus.i_ac_ready = 1'b0;
        bus.i_cr_valid = 1'b1; bus.i_cr_resp = 5'b00001;
        tick();
        bus.i_cr_valid = 1'b0;
        beat(64'h5555_5555_5555_5555, 1'b0);
        beat(64'h6666_6666_6666_6666, 1'b0);
        nrst = 1'b0;
        #1;
        chk("t5_rst_req_ready", bus.o_req_ready, 0);
        chk("t5_rst_cd_ready", bus.o_cd_ready, 0);
        chk("t5_rst_ac_addr", bus.o_ac_addr, 0);
        chk("t5_rst_resp_cr", bus.o_resp_cr, 0);
        chk("t5_rst_resp_data", bus.o_resp_data, 0);
        tick();
        nrst = 1'b1;
        tick();
        chk("t5_rel_req_ready", bus.o_req_ready, 1);
        issue(48'h0000_0000_4000, 4'b1000);
        bus.i_ac_ready = 1'b1;
        tick();
        bus.i_ac_ready = 1'b0;
        bus.i_cr_valid = 1'b1; bus.i_cr_resp = 5'b00001;
        tick();
        bus.i_cr_valid = 1'b0;
        beat(64'h7777_7777_7777_7777, 1'b1);
        chk("t5_resp_valid", bus.o_resp_valid, 1);
        chk("t5_clean_line", bus.o_resp_data, {192'h0, 64'h7777_7777_7777_7777});
        bus.i_resp_ready = 1'b1;
        tick();
        bus.i_resp_ready = 1'b0;

        // Watchdog: no CR ever
        issue(48'h0000_0000_5000, 4'b0000);
        bus.i_ac_ready = 1'b1;
        tick();
        bus.i_ac_ready = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        chk("t6_no_resp_at_16", bus.o_resp_valid, 0);
        tick();
        chk("t6_tmo_resp_valid", bus.o_resp_valid, 1);
        chk("t6_tmo_flag", bus.o_resp_timeout, 1);
        chk("t6_tmo_cr", bus.o_resp_cr, 0);
        bus.i_resp_ready = 1'b1;
        tick();
        bus.i_resp_ready = 1'b0;
        chk("t6_idle", bus.o_req_ready, 1);
`else
        for (int i = 0; i < 1000; i++) tick();
        chk("t6_no_resp_1000", bus.o_resp_valid, 0);
        chk("t6_still_waiting", bus.o_cr_ready, 1);
        bus.i_cr_valid = 1'b1; bus.i_cr_resp = 5'b01000;
        tick();
        bus.i_cr_valid = 1'b0;
        chk("t6_late_resp", bus.o_resp_valid, 1);
        chk("t6_late_cr", bus.o_resp_cr, 5'h08);
        chk("t6_no_tmo", bus.o_resp_timeout, 0);
        bus.i_resp_ready = 1'b1;
        tick();
        bus.i_resp_ready = 1'b0;
        chk("t6_idle", bus.o_req_ready, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
